// File: rtl/mpt_fetch_arbiter_if.sv
// Valid/ready/data bundle with LANES parallel lanes; the arbiter uses one instance per side.

interface mpt_fetch_arbiter_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 128,
  parameter int CHID_W = 1
);
  logic [LANES-1:0]             valid;
  logic [LANES-1:0]             ready;
  logic [LANES-1:0][DATA_W-1:0] data;
  logic [CHID_W-1:0]            chid;

  modport master (output valid, output data, output chid, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mpt_fetch_arbiter.sv
// MPT walker fetch stage: per-channel FIFOs, round-robin arbitration, MODE format check.
// Optional MPT_FETCH_FAULT_CNT_EN adds a saturating fault counter output fault_count_o.

package mpt_fetch_pkg;

  localparam logic [3:0] BARE_MODE    = 4'h0;
  localparam logic [3:0] SMMPT43_MODE = 4'h1;
  localparam logic [3:0] SMMPT52_MODE = 4'h2;
  localparam logic [3:0] SMMPT64_MODE = 4'h3;

  typedef struct packed {
    logic [3:0]  MODE;
    logic [15:0] SDID;
    logic [43:0] PPN;
  } mmpt_t;

  typedef struct packed {
    logic [20:0] ZERO;
    logic [42:0] ADDR;
  } spa43_t;

  typedef struct packed {
    logic [11:0] ZERO;
    logic [51:0] ADDR;
  } spa52_t;

  typedef union packed {
    spa43_t      spa43;
    spa52_t      spa52;
    logic [63:0] raw;
  } spa_t;

  typedef struct packed {
    mmpt_t mmpt;
    spa_t  spa;
  } mptw_transaction_t;

  typedef enum logic [1:0] {
    NO_ERROR       = 2'd0,
    NOT_VALID_ADDR = 2'd1
  } page_format_fault_e;

endpackage

module mpt_fetch_arbiter
  import mpt_fetch_pkg::*;
#(
  parameter int NUM_CHANNELS        = 2,
  parameter int FIFO_DEPTH          = 4,
  parameter int PIPELINE_DATA_WIDTH = $bits(mptw_transaction_t),
  parameter int CHID_W              = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  mpt_fetch_arbiter_if.slave         fetch_slave,
  mpt_fetch_arbiter_if.master        fetch_master,
  input  logic                       fetch_control_flush,
  output logic                       exception_valid_o,
  output page_format_fault_e         exception_cause_o,
  output logic [CHID_W-1:0]          exception_chid_o
`ifdef MPT_FETCH_FAULT_CNT_EN
  ,
  output logic [31:0]                fault_count_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [PIPELINE_DATA_WIDTH-1:0] data_t;

  data_t                   fifo_mem [NUM_CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr   [NUM_CHANNELS];
  logic [PTR_W-1:0]        rd_ptr   [NUM_CHANNELS];
  logic [CNT_W-1:0]        count    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] full;
  logic [NUM_CHANNELS-1:0] empty;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;

  logic [CHID_W-1:0]       rr_ptr;
  logic [CHID_W-1:0]       winner;
  logic                    winner_exists;
  mptw_transaction_t       head;
  page_format_fault_e      head_cause;
  logic                    fault;
  logic                    out_free;
  logic                    pop_en;

  logic                    out_valid;
  data_t                   out_data;
  logic [CHID_W-1:0]       out_chid;

  // ---------------------------------------------------------------------------
  // Slave side and FIFO status
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      full[c]  = (count[c] == CNT_W'(FIFO_DEPTH));
      empty[c] = (count[c] == '0);
    end
  end

  // Ready depends only on registered occupancy, reset and flush; never on the master side.
  assign fetch_slave.ready = (rst_ni && !fetch_control_flush) ? ~full : '0;
  assign push              = fetch_slave.valid & fetch_slave.ready;

  // NOTE: storage carries no reset; only pointers and counts define what is valid.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c]) begin
        fifo_mem[c][wr_ptr[c]] <= fetch_slave.data[c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || fetch_control_flush) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty channel at or after rr_ptr
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    idx           = 0;
    winner_exists = 1'b0;
    winner        = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (!winner_exists && !empty[idx]) begin
        winner_exists = 1'b1;
        winner        = CHID_W'(idx);
      end
    end
  end

  assign head = fifo_mem[winner][rd_ptr[winner]];

  always_comb begin
    head_cause = NO_ERROR;
    case (head.mmpt.MODE)
      BARE_MODE:    head_cause = NOT_VALID_ADDR;
      SMMPT43_MODE: if (head.spa.spa43.ZERO != '0) head_cause = NOT_VALID_ADDR;
      SMMPT52_MODE: if (head.spa.spa52.ZERO != '0) head_cause = NOT_VALID_ADDR;
      SMMPT64_MODE: head_cause = NO_ERROR;
      default:      head_cause = NOT_VALID_ADDR;
    endcase
  end

  // Faulting heads pop regardless of backpressure so they never queue behind a stalled output.
  assign fault    = (head_cause != NO_ERROR);
  assign out_free = !out_valid || fetch_master.ready[0];
  assign pop_en   = winner_exists && (fault || out_free) && !fetch_control_flush;

  always_comb begin
    pop = '0;
    if (pop_en) pop[winner] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || fetch_control_flush) begin
      rr_ptr <= '0;
    end else if (pop_en) begin
      rr_ptr <= (winner == CHID_W'(NUM_CHANNELS - 1)) ? '0 : winner + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered master port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chid  <= '0;
    end else if (fetch_control_flush) begin
      out_valid <= 1'b0;
    end else if (pop_en && !fault) begin
      out_valid <= 1'b1;
      out_data  <= head;
      out_chid  <= winner;
    end else if (fetch_master.ready[0]) begin
      out_valid <= 1'b0;
    end
  end

  assign fetch_master.valid   = out_valid;
  assign fetch_master.data[0] = out_data;
  assign fetch_master.chid    = out_chid;

  // ---------------------------------------------------------------------------
  // Exception pulse, one cycle per discarded transaction
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exception_valid_o <= 1'b0;
      exception_cause_o <= NO_ERROR;
      exception_chid_o  <= '0;
    end else if (fetch_control_flush) begin
      exception_valid_o <= 1'b0;
      exception_cause_o <= NO_ERROR;
    end else if (pop_en && fault) begin
      exception_valid_o <= 1'b1;
      exception_cause_o <= head_cause;
      exception_chid_o  <= winner;
    end else begin
      exception_valid_o <= 1'b0;
      exception_cause_o <= NO_ERROR;
    end
  end

`ifdef MPT_FETCH_FAULT_CNT_EN
  // Survives flush so software can read the total since the last reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fault_count_o <= '0;
    end else if (exception_valid_o && (fault_count_o != 32'hFFFF_FFFF)) begin
      fault_count_o <= fault_count_o + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid && !fetch_master.ready[0] && !fetch_control_flush
    |=> out_valid && $stable(out_data) && $stable(out_chid));

  a_cause_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !exception_valid_o |-> exception_cause_o == NO_ERROR);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push & full) == '0);

endmodule

// File: tb/tb_mpt_fetch_arbiter.sv
// Scoreboard bench for mpt_fetch_arbiter: directed stimulus pushes expectations, a monitor pops them.

module tb_mpt_fetch_arbiter;
  import mpt_fetch_pkg::*;

  localparam int N  = 2;
  localparam int DW = $bits(mptw_transaction_t);
  localparam int CW = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic exc_valid;
  page_format_fault_e exc_cause;
  logic [CW-1:0] exc_chid;
`ifdef MPT_FETCH_FAULT_CNT_EN
  logic [31:0] fault_count;
`endif

  always #5 clk = ~clk;

  mpt_fetch_arbiter_if #(.LANES(N), .DATA_W(DW), .CHID_W(CW)) slv ();
  mpt_fetch_arbiter_if #(.LANES(1), .DATA_W(DW), .CHID_W(CW)) mst ();

  mpt_fetch_arbiter #(.NUM_CHANNELS(N), .FIFO_DEPTH(4)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .fetch_slave         (slv.slave),
    .fetch_master        (mst.master),
    .fetch_control_flush (flush),
    .exception_valid_o   (exc_valid),
    .exception_cause_o   (exc_cause),
    .exception_chid_o    (exc_chid)
`ifdef MPT_FETCH_FAULT_CNT_EN
    ,
    .fault_count_o       (fault_count)
`endif
  );

  typedef struct packed {
    logic [CW-1:0]     chid;
    mptw_transaction_t data;
  } out_exp_t;

  typedef struct packed {
    logic [CW-1:0]      chid;
    page_format_fault_e cause;
  } exc_exp_t;

  out_exp_t out_q[$];
  exc_exp_t exc_q[$];
  int       out_cyc[$];
  int       exc_cyc[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  int       exp_fault_cnt = 0;
  bit       mon_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic mptw_transaction_t mk(input logic [3:0] mode, input logic [63:0] spa,
                                           input logic [43:0] tag);
    mptw_transaction_t t;
    t.mmpt.MODE = mode;
    t.mmpt.SDID = 16'h5A5A;
    t.mmpt.PPN  = tag;
    t.spa.raw   = spa;
    return t;
  endfunction

  task automatic expect_out(input int ch, input mptw_transaction_t d);
    out_q.push_back('{chid: CW'(ch), data: d});
  endtask

  task automatic expect_exc(input int ch);
    exc_q.push_back('{chid: CW'(ch), cause: NOT_VALID_ADDR});
    exp_fault_cnt++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds valid on channel ch until a handshake edge, bounded; returns at edge + 1.
  task automatic send(input int ch, input mptw_transaction_t d);
    bit done;
    done = 1'b0;
    slv.valid[ch] = 1'b1;
    slv.data[ch]  = d;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = slv.ready[ch];
      @(posedge clk);
    end
    #1;
    slv.valid[ch] = 1'b0;
    check($sformatf("send_hs_ch%0d", ch), done, 1'b1);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && (out_q.size() != 0 || exc_q.size() != 0); k++) @(posedge clk);
    #1;
    check("drain_out_q", out_q.size(), 0);
    check("drain_exc_q", exc_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every accepted output and every exception pulse against the queues.
  initial begin
    out_exp_t oe;
    exc_exp_t ee;
    forever begin
      @(negedge clk);
      if (mon_en && mst.valid[0] && mst.ready[0]) begin
        out_cyc.push_back(cyc);
        if (out_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: got chid %0d data %0h, expected no output",
                   mst.chid, mst.data[0]);
        end else begin
          oe = out_q.pop_front();
          check("out_chid", mst.chid, oe.chid);
          check("out_data", mst.data[0], oe.data);
        end
      end
      if (mon_en && exc_valid) begin
        exc_cyc.push_back(cyc);
        if (exc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL exc_unexpected: got chid %0d cause %0d, expected no exception",
                   exc_chid, exc_cause);
        end else begin
          ee = exc_q.pop_front();
          check("exc_chid", exc_chid, ee.chid);
          check("exc_cause", exc_cause, ee.cause);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mptw_transaction_t a [4];
    mptw_transaction_t b [4];
    mptw_transaction_t c [5];
    mptw_transaction_t d, g;
    int span;

    rst_n        = 1'b0;
    flush        = 1'b0;
    slv.valid    = '0;
    slv.data     = '0;
    slv.chid     = '0;
    mst.ready    = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", slv.ready, 2'b00);
    check("rst_valid_low", mst.valid, 1'b0);
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", slv.ready, 2'b11);
    check("post_rst_valid", mst.valid, 1'b0);
    check("post_rst_wdata", mst.data[0], '0);
    check("post_rst_chid", mst.chid, 0);
    check("post_rst_exc_valid", exc_valid, 1'b0);
    check("post_rst_exc_cause", exc_cause, NO_ERROR);
    check("post_rst_exc_chid", exc_chid, 0);
    mon_en = 1'b1;

    // Single good SMMPT43 transaction, two-cycle latency
    tick(1);
    d = mk(SMMPT43_MODE, 64'h0000_0123_4567_8000, 44'h1);
    expect_out(0, d);
    send(0, d);
    @(negedge clk);
    check("lat_t1_valid", mst.valid, 1'b0);
    @(negedge clk);
    check("lat_t2_valid", mst.valid, 1'b1);
    wait_drain(10);

    // Fairness and full throughput from rr_ptr = 0
    tick(1);
    flush_pulse();
    for (int i = 0; i < 4; i++) begin
      a[i] = mk(SMMPT64_MODE, 64'(i) + 64'hA000, 44'h100 + 44'(i));
      b[i] = mk(SMMPT52_MODE, 64'h000F_0000_0000_0000 | 64'(i), 44'h200 + 44'(i));
    end
    for (int i = 0; i < 4; i++) begin
      expect_out(0, a[i]);
      expect_out(1, b[i]);
    end
    out_cyc.delete();
    fork
      begin for (int i = 0; i < 4; i++) send(0, a[i]); end
      begin for (int i = 0; i < 4; i++) send(1, b[i]); end
    join
    wait_drain(30);
    check("fair_out_count", out_cyc.size(), 8);
    span = (out_cyc.size() > 0) ? out_cyc[out_cyc.size()-1] - out_cyc[0] : -1;
    check("fair_back_to_back", span, 7);

    // Backpressure on channel 1: 1 in output register + 4 queued
    tick(1);
    mst.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c[i] = mk(SMMPT43_MODE, 64'h0000_0000_0000_1000 * 64'(i + 1), 44'h300 + 44'(i));
      expect_out(1, c[i]);
    end
    for (int i = 0; i < 5; i++) send(1, c[i]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", mst.data[0], c[0]);
    end
    check("bp_hold_valid", mst.valid, 1'b1);
    check("bp_ch1_ready_low", slv.ready[1], 1'b0);
    check("bp_ch0_ready_high", slv.ready[0], 1'b1);
    tick(1);
    mst.ready = 1'b1;
    wait_drain(30);

    // Faults bypassing a stalled output
    tick(1);
    mst.ready = 1'b0;
    g = mk(SMMPT64_MODE, 64'hFFFF_0000_FFFF_0000, 44'h400);
    expect_out(1, g);
    send(1, g);
    tick(2);
    exc_cyc.delete();
    expect_exc(0);
    expect_exc(0);
    expect_exc(0);
    send(0, mk(BARE_MODE, 64'h0, 44'h401));
    send(0, mk(4'hF, 64'h0, 44'h402));
    send(0, mk(SMMPT52_MODE, 64'h1000_0000_0000_0000, 44'h403));
    repeat (4) @(negedge clk);
    check("fault_pulse_count", exc_cyc.size(), 3);
    span = (exc_cyc.size() > 0) ? exc_cyc[exc_cyc.size()-1] - exc_cyc[0] : -1;
    check("fault_pulses_consecutive", span, 2);
    check("fault_out_valid_held", mst.valid, 1'b1);
    check("fault_out_data_held", mst.data[0], g);
`ifdef MPT_FETCH_FAULT_CNT_EN
    check("fault_count_3", fault_count, exp_fault_cnt);
`endif
    tick(1);
    mst.ready = 1'b1;
    wait_drain(20);

    // Flush with data in FIFOs and a valid output; nothing stale may surface
    tick(1);
    mst.ready = 1'b0;
    send(0, mk(SMMPT64_MODE, 64'h1, 44'h500));
    send(1, mk(SMMPT64_MODE, 64'h2, 44'h501));
    send(0, mk(SMMPT64_MODE, 64'h3, 44'h502));
    send(1, mk(SMMPT64_MODE, 64'h4, 44'h503));
    @(negedge clk);
    check("flush_pre_valid", mst.valid, 1'b1);
    tick(1);
    flush_pulse();
    @(negedge clk);
    check("flush_ready_all", slv.ready, 2'b11);
    check("flush_valid_clr", mst.valid, 1'b0);
    tick(1);
    mst.ready = 1'b1;
    repeat (8) @(negedge clk);
    check("flush_no_stale", mst.valid, 1'b0);

    // Reset in the middle of streaming traffic
    tick(1);
    mon_en    = 1'b0;
    slv.data[0] = mk(SMMPT64_MODE, 64'h77, 44'h600);
    slv.data[1] = mk(SMMPT43_MODE, 64'h0, 44'h601);
    slv.valid = 2'b11;
    tick(3);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_low", slv.ready, 2'b00);
    tick(1);
    rst_n     = 1'b1;
    slv.valid = 2'b00;
    @(negedge clk);
    check("mid_rst_valid", mst.valid, 1'b0);
    check("mid_rst_wdata", mst.data[0], '0);
    check("mid_rst_chid", mst.chid, 0);
    check("mid_rst_exc_valid", exc_valid, 1'b0);
    check("mid_rst_exc_cause", exc_cause, NO_ERROR);
    check("mid_rst_ready", slv.ready, 2'b11);
    repeat (3) @(negedge clk);
    check("mid_rst_no_partial", mst.valid, 1'b0);
    out_q.delete();
    exc_q.delete();
    exp_fault_cnt = 0;
`ifdef MPT_FETCH_FAULT_CNT_EN
    check("mid_rst_fault_count", fault_count, 0);
`endif
    mon_en = 1'b1;

    // Mixed format patterns across both channels
    tick(1);
    expect_out(0, mk(SMMPT64_MODE, 64'hFFFF_FFFF_FFFF_FFFF, 44'h700));
    expect_exc(1);
    expect_out(0, mk(SMMPT52_MODE, 64'h000F_FFFF_FFFF_FFFF, 44'h702));
    expect_exc(1);
    send(0, mk(SMMPT64_MODE, 64'hFFFF_FFFF_FFFF_FFFF, 44'h700));
    send(1, mk(SMMPT43_MODE, 64'h0000_0800_0000_0000, 44'h701));
    send(0, mk(SMMPT52_MODE, 64'h000F_FFFF_FFFF_FFFF, 44'h702));
    send(1, mk(4'h4, 64'h0, 44'h703));
    wait_drain(20);
`ifdef MPT_FETCH_FAULT_CNT_EN
    check("mixed_fault_count", fault_count, exp_fault_cnt);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
